// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle MIPS instruction-sequencing controller
module multicycle_control_unit #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ENABLE_BNE    = 1'b1,
    parameter bit ENABLE_ADDI   = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    state_t     state;
    state_t     next_state;
    logic       rdy;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       pc_en_raw;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       illegal_raw;

    assign rdy = MEM_HANDSHAKE ? MemReady : 1'b1;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (Funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        next_state    = S_FETCH;
        pc_write      = 1'b0;
        branch        = 1'b0;
        branch_ne     = 1'b0;
        IorD          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        RegDst        = 1'b0;
        MemToReg      = 1'b0;
        reg_write_raw = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        PCSrc         = 2'b00;
        illegal_raw   = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB      = 2'b01;
                ir_write_raw = rdy;
                pc_write     = rdy;
                next_state   = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (OpCode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_ok) next_state = S_EXECUTE;
                        else          illegal_raw = 1'b1;
                    end
                    OP_BEQ: next_state = S_BRANCH;
                    OP_BNE: begin
                        if (ENABLE_BNE) next_state = S_BRANCH;
                        else            illegal_raw = 1'b1;
                    end
                    OP_ADDI: begin
                        if (ENABLE_ADDI) next_state = S_ADDIEX;
                        else             illegal_raw = 1'b1;
                    end
                    OP_J:    next_state  = S_JUMP;
                    default: illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (OpCode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                IorD       = 1'b1;
                next_state = rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                MemToReg      = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                // strobe stays up for the whole wait so memory sees a stable request
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
                next_state    = rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                branch     = (OpCode == OP_BEQ);
                branch_ne  = (OpCode == OP_BNE);
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
            end
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    assign pc_en_raw = pc_write | (branch & Zero) | (branch_ne & ~Zero);

    // reset gates the strobes directly so an aborted access drops without waiting for a clock
    assign PCEn      = RST & pc_en_raw;
    assign IRWrite   = RST & ir_write_raw;
    assign MemWrite  = RST & mem_write_raw;
    assign RegWrite  = RST & reg_write_raw;
    assign IllegalOp = RST & illegal_raw;
    assign State     = state;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_FETCH;
        else      state <= next_state;
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - table-driven checks of the multicycle controller
module tb_multicycle_control_unit;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [5:0] OpCode = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b1;

    logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic       IllegalOp;
    logic [3:0] State;

    logic       nb_PCEn, nb_IorD, nb_MemWrite, nb_IRWrite, nb_RegDst, nb_MemToReg, nb_RegWrite, nb_ALUSrcA;
    logic [1:0] nb_ALUSrcB, nb_PCSrc;
    logic [2:0] nb_ALUControl;
    logic       nb_IllegalOp;
    logic [3:0] nb_State;

    multicycle_control_unit dut (
        .CLK(CLK), .RST(RST), .OpCode(OpCode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
        .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .PCSrc(PCSrc), .IllegalOp(IllegalOp), .State(State)
    );

    multicycle_control_unit #(.MEM_HANDSHAKE(1'b0), .ENABLE_BNE(1'b0), .ENABLE_ADDI(1'b0)) dut_nb (
        .CLK(CLK), .RST(RST), .OpCode(OpCode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
        .PCEn(nb_PCEn), .IorD(nb_IorD), .MemWrite(nb_MemWrite), .IRWrite(nb_IRWrite), .RegDst(nb_RegDst),
        .MemToReg(nb_MemToReg), .RegWrite(nb_RegWrite), .ALUSrcA(nb_ALUSrcA), .ALUSrcB(nb_ALUSrcB),
        .ALUControl(nb_ALUControl), .PCSrc(nb_PCSrc), .IllegalOp(nb_IllegalOp), .State(nb_State)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // {State, PCEn, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, IllegalOp}
    function automatic logic [19:0] ex(input logic [3:0] st, input logic pcen, input logic iord,
                                       input logic mw, input logic irw, input logic rd, input logic m2r,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic [2:0] aluc, input logic [1:0] pcsrc, input logic ill);
        return {st, pcen, iord, mw, irw, rd, m2r, rw, asa, asb, aluc, pcsrc, ill};
    endfunction

    task automatic add(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                       input logic rdy, input logic [19:0] exp);
        vec_t v;
        v.op = op; v.funct = funct; v.zero = zero; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [19:0] outs();
        return {State, PCEn, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUControl, PCSrc, IllegalOp};
    endfunction

    task automatic add_rtype(input logic [5:0] funct, input logic [2:0] aluc,
                             input logic [19:0] f, input logic [19:0] d);
        add(6'b000000, funct, 1'b0, 1'b1, f);
        add(6'b000000, funct, 1'b0, 1'b1, d);
        add(6'b000000, funct, 1'b0, 1'b1, ex(6, 0,0,0,0, 0,0,0, 1, 2'b00, aluc, 2'b00, 0));
        add(6'b000000, funct, 1'b0, 1'b1, ex(7, 0,0,0,0, 1,0,1, 0, 2'b00, 3'b010, 2'b00, 0));
    endtask

    task automatic add_branch(input logic [5:0] op, input logic zero, input logic pcen,
                              input logic [19:0] f, input logic [19:0] d);
        add(op, 6'd0, zero, 1'b1, f);
        add(op, 6'd0, zero, 1'b1, d);
        add(op, 6'd0, zero, 1'b1, ex(8, pcen,0,0,0, 0,0,0, 1, 2'b00, 3'b110, 2'b01, 0));
    endtask

    initial begin
        logic [19:0] f, f_stall, d, d_ill;
        int mw_cycles, irw_cycles;

        f       = ex(0, 1,0,0,1, 0,0,0, 0, 2'b01, 3'b010, 2'b00, 0);
        f_stall = ex(0, 0,0,0,0, 0,0,0, 0, 2'b01, 3'b010, 2'b00, 0);
        d       = ex(1, 0,0,0,0, 0,0,0, 0, 2'b11, 3'b010, 2'b00, 0);
        d_ill   = ex(1, 0,0,0,0, 0,0,0, 0, 2'b11, 3'b010, 2'b00, 1);

        // lw with one MEMREAD wait and one FETCH stall
        add(6'b100011, 6'd0, 1'b0, 1'b0, f_stall);
        add(6'b100011, 6'd0, 1'b0, 1'b1, f);
        add(6'b100011, 6'd0, 1'b0, 1'b1, d);
        add(6'b100011, 6'd0, 1'b0, 1'b1, ex(2, 0,0,0,0, 0,0,0, 1, 2'b10, 3'b010, 2'b00, 0));
        add(6'b100011, 6'd0, 1'b0, 1'b0, ex(3, 0,1,0,0, 0,0,0, 0, 2'b00, 3'b010, 2'b00, 0));
        add(6'b100011, 6'd0, 1'b0, 1'b1, ex(3, 0,1,0,0, 0,0,0, 0, 2'b00, 3'b010, 2'b00, 0));
        add(6'b100011, 6'd0, 1'b0, 1'b1, ex(4, 0,0,0,0, 0,1,1, 0, 2'b00, 3'b010, 2'b00, 0));
        // sw
        add(6'b101011, 6'd0, 1'b0, 1'b1, f);
        add(6'b101011, 6'd0, 1'b0, 1'b1, d);
        add(6'b101011, 6'd0, 1'b0, 1'b1, ex(2, 0,0,0,0, 0,0,0, 1, 2'b10, 3'b010, 2'b00, 0));
        add(6'b101011, 6'd0, 1'b0, 1'b1, ex(5, 0,1,1,0, 0,0,0, 0, 2'b00, 3'b010, 2'b00, 0));
        // R-type functs
        add_rtype(6'b100000, 3'b010, f, d);
        add_rtype(6'b100010, 3'b110, f, d);
        add_rtype(6'b100100, 3'b000, f, d);
        add_rtype(6'b100101, 3'b001, f, d);
        add_rtype(6'b101010, 3'b111, f, d);
        add(6'b000000, 6'b000111, 1'b0, 1'b1, f);
        add(6'b000000, 6'b000111, 1'b0, 1'b1, d_ill);
        // branches
        add_branch(6'b000100, 1'b1, 1'b1, f, d);
        add_branch(6'b000100, 1'b0, 1'b0, f, d);
        add_branch(6'b000101, 1'b0, 1'b1, f, d);
        add_branch(6'b000101, 1'b1, 1'b0, f, d);
        // addi
        add(6'b001000, 6'd0, 1'b0, 1'b1, f);
        add(6'b001000, 6'd0, 1'b0, 1'b1, d);
        add(6'b001000, 6'd0, 1'b0, 1'b1, ex(9, 0,0,0,0, 0,0,0, 1, 2'b10, 3'b010, 2'b00, 0));
        add(6'b001000, 6'd0, 1'b0, 1'b1, ex(10, 0,0,0,0, 0,0,1, 0, 2'b00, 3'b010, 2'b00, 0));
        // j
        add(6'b000010, 6'd0, 1'b0, 1'b1, f);
        add(6'b000010, 6'd0, 1'b0, 1'b1, d);
        add(6'b000010, 6'd0, 1'b0, 1'b1, ex(11, 1,0,0,0, 0,0,0, 0, 2'b00, 3'b010, 2'b10, 0));
        // unknown opcode
        add(6'b111111, 6'd0, 1'b0, 1'b1, f);
        add(6'b111111, 6'd0, 1'b0, 1'b1, d_ill);

        // reset state
        RST = 1'b0;
        #1;
        chk("reset_outputs", {12'd0, outs()}, {12'd0, ex(0, 0,0,0,0, 0,0,0, 0, 2'b01, 3'b010, 2'b00, 0)});
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            OpCode = vecs[i].op; Funct = vecs[i].funct; Zero = vecs[i].zero; MemReady = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_op%b", i, vecs[i].op), {12'd0, outs()}, {12'd0, vecs[i].exp});
            @(posedge CLK);
            #1;
            @(negedge CLK);
        end

        // sw with 2-cycle FETCH stall and 3-cycle MEMWRITE wait
        OpCode = 6'b101011; Funct = 6'd0; Zero = 1'b0; MemReady = 1'b0;
        mw_cycles = 0; irw_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            MemReady = (i == 2);
            #1;
            chk($sformatf("sw_fetch_state%0d", i), {28'd0, State}, 32'd0);
            irw_cycles += int'(IRWrite);
            @(posedge CLK);
            @(negedge CLK);
        end
        chk("sw_irwrite_cycles", irw_cycles, 1);
        chk("sw_decode_state", {28'd0, State}, 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            MemReady = (i == 3);
            #1;
            chk($sformatf("sw_memwrite_state%0d", i), {28'd0, State}, 32'd5);
            mw_cycles += int'(MemWrite);
            @(posedge CLK);
            @(negedge CLK);
        end
        chk("sw_memwrite_cycles", mw_cycles, 4);
        chk("sw_return_fetch", {28'd0, State}, 32'd0);

        // asynchronous reset while a MEMWRITE is waiting
        MemReady = 1'b1;
        for (int i = 0; i < 3; i++) @(posedge CLK);
        #1;
        MemReady = 1'b0;
        #2;
        chk("pre_reset_memwrite", {31'd0, MemWrite}, 32'd1);
        RST = 1'b0;
        #1;
        chk("reset_memwrite_drop", {31'd0, MemWrite}, 32'd0);
        chk("reset_state", {28'd0, State}, 32'd0);
        chk("reset_strobes", {29'd0, PCEn, IRWrite, RegWrite}, 32'd0);
        @(negedge CLK);
        RST = 1'b1; MemReady = 1'b1; OpCode = 6'b000101;
        #1;
        chk("post_reset_fetch", {28'd0, State, PCEn, IRWrite}, {28'd0, 4'd0, 1'b1, 1'b1});
        chk("nohs_fetch_pcen", {31'd0, nb_PCEn}, 32'd1);

        // same bne opcode on the instance without bne support
        @(posedge CLK);
        #1;
        chk("bne_enabled_decode", {27'd0, State, IllegalOp}, {27'd0, 4'd1, 1'b0});
        chk("bne_disabled_decode", {27'd0, nb_State, nb_IllegalOp}, {27'd0, 4'd1, 1'b1});
        chk("bne_disabled_nowrite", {29'd0, nb_RegWrite, nb_MemWrite, nb_PCEn}, 32'd0);
        @(posedge CLK);
        #1;
        chk("bne_disabled_next", {28'd0, nb_State}, 32'd0);
        chk("bne_enabled_branch", {28'd0, State}, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
